// File: rtl/jtopl_eg_pkg.sv
// Shared definitions for the OPL envelope phase sequencer.
package jtopl_eg_pkg;

    // Envelope phase codes
    typedef enum logic [1:0] {
        ATTACK  = 2'd0,
        DECAY   = 2'd1,
        SUSTAIN = 2'd2,
        RELEASE = 2'd3
    } eg_state_t;

    // Sustain level used when sl==15 (fully attenuated threshold)
    localparam logic [4:0] SL_MAX = 5'd31;

    localparam int unsigned SLOT_W = 5;
    localparam int unsigned RATE_W = 5;

endpackage

// File: rtl/jtopl_eg_next.sv
// Combinational next-phase and rate selection for one envelope slot.
module jtopl_eg_next
    import jtopl_eg_pkg::*;
(
    input  eg_state_t          state,
    input  logic               last_keyon,
    input  logic               keyon,
    input  logic [8:0]         eg_in,
    input  logic [3:0]         sl,
    input  logic               eg_type,
    input  logic [3:0]         ar,
    input  logic [3:0]         dr,
    input  logic [3:0]         rr,
    output eg_state_t          next_state,
    output logic [RATE_W-1:0]  base_rate
);

    logic [4:0] w_sl_eff;
    logic [3:0] w_rate;

    assign w_sl_eff = (sl == 4'd15) ? SL_MAX : {1'b0, sl};

    // Phase transition, first matching rule wins
    always_comb begin
        next_state = state;
        if (keyon && !last_keyon) begin
            next_state = ATTACK;
        end else if (!keyon && state != RELEASE) begin
            next_state = RELEASE;
        end else if (state == ATTACK && eg_in == 9'd0) begin
            next_state = DECAY;
        end else if (state == DECAY && eg_in[8:4] >= w_sl_eff) begin
            next_state = eg_type ? SUSTAIN : RELEASE;
        end else if (state == SUSTAIN && !eg_type) begin
            next_state = RELEASE;
        end
    end

    // Rate of the phase the slot is entering; a zero rate stays zero
    always_comb begin
        w_rate = rr;
        case (next_state)
            ATTACK:  w_rate = ar;
            DECAY:   w_rate = dr;
            SUSTAIN: w_rate = eg_type ? 4'd0 : rr;
            RELEASE: w_rate = rr;
            default: w_rate = rr;
        endcase
        base_rate = (w_rate == 4'd0) ? 5'd0 : {w_rate, 1'b0};
    end

endmodule

// File: rtl/jtopl_eg_ctrl.sv
// Time-multiplexed envelope phase sequencer: per-slot phase, key-on history,
// step-stage cnt memory and the global envelope counter.
module jtopl_eg_ctrl
    import jtopl_eg_pkg::*;
#(
    parameter int unsigned SLOTS = 18,
    parameter int unsigned CNTW  = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cen,
    input  logic               keyon,
    input  logic [3:0]         ar,
    input  logic [3:0]         dr,
    input  logic [3:0]         sl,
    input  logic [3:0]         rr,
    input  logic               eg_type,
    input  logic [8:0]         eg_in,
    input  logic               cnt_lsb,
    output logic [SLOT_W-1:0]  slot_out,
    output logic               attack,
    output logic [RATE_W-1:0]  base_rate,
    output logic [1:0]         state_out,
    output logic               cnt_in,
    output logic [CNTW-1:0]    eg_cnt,
    output logic               sample
);

    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(SLOTS - 1);

    eg_state_t         r_state  [SLOTS];
    logic              r_keyon  [SLOTS];
    logic              r_cntmem [SLOTS];
    logic [SLOT_W-1:0] r_cur;

    eg_state_t         w_next;
    logic [RATE_W-1:0] w_base_rate;

    jtopl_eg_next u_next (
        .state      (r_state[r_cur]),
        .last_keyon (r_keyon[r_cur]),
        .keyon      (keyon),
        .eg_in      (eg_in),
        .sl         (sl),
        .eg_type    (eg_type),
        .ar         (ar),
        .dr         (dr),
        .rr         (rr),
        .next_state (w_next),
        .base_rate  (w_base_rate)
    );

    // Slot ring, per-slot memories, global counter and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(SLOTS); i++) begin
                r_state[i]  <= RELEASE;
                r_keyon[i]  <= 1'b0;
                r_cntmem[i] <= 1'b0;
            end
            r_cur     <= '0;
            slot_out  <= '0;
            attack    <= 1'b0;
            base_rate <= '0;
            state_out <= '0;
            cnt_in    <= 1'b0;
            eg_cnt    <= '0;
            sample    <= 1'b0;
        end else begin
            sample <= 1'b0;
            if (cen) begin
                r_cur              <= (r_cur == LAST_SLOT) ? '0 : r_cur + SLOT_W'(1);
                eg_cnt             <= (r_cur == LAST_SLOT) ? eg_cnt + CNTW'(1) : eg_cnt;
                r_state[r_cur]     <= w_next;
                r_keyon[r_cur]     <= keyon;
                r_cntmem[slot_out] <= cnt_lsb;
                cnt_in             <= r_cntmem[r_cur];
                slot_out           <= r_cur;
                state_out          <= w_next;
                attack             <= (w_next == ATTACK);
                base_rate          <= w_base_rate;
                sample             <= (r_cur == '0);
            end
        end
    end

endmodule

// File: tb/tb_jtopl_eg_ctrl.sv
// Bench for jtopl_eg_ctrl: directed phase scenarios plus randomized rings,
// checked against a per-slot behavioural model.
module tb_jtopl_eg_ctrl;

    localparam int SLOTS = 18;
    localparam int CNTW  = 4;

    logic       clk = 1'b0;
    logic       rst, cen, keyon, eg_type, cnt_lsb;
    logic [3:0] ar, dr, sl, rr;
    logic [8:0] eg_in;
    logic [4:0] slot_out, base_rate;
    logic       attack, cnt_in, sample;
    logic [1:0] state_out;
    logic [CNTW-1:0] eg_cnt;

    jtopl_eg_ctrl #(.SLOTS(SLOTS), .CNTW(CNTW)) dut (
        .clk(clk), .rst(rst), .cen(cen), .keyon(keyon), .ar(ar), .dr(dr),
        .sl(sl), .rr(rr), .eg_type(eg_type), .eg_in(eg_in), .cnt_lsb(cnt_lsb),
        .slot_out(slot_out), .attack(attack), .base_rate(base_rate),
        .state_out(state_out), .cnt_in(cnt_in), .eg_cnt(eg_cnt), .sample(sample)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Stimulus per slot
    int t_kon[SLOTS], t_ar[SLOTS], t_dr[SLOTS], t_sl[SLOTS], t_rr[SLOTS];
    int t_et[SLOTS], t_eg[SLOTS];
    int rnd_mode = 0;
    int cl_mode  = 0;

    // Reference model: phase 0=attack 1=decay 2=sustain 3=release
    int m_st[SLOTS], m_lk[SLOTS], m_mem[SLOTS];
    int m_cur, m_egcnt;
    int e_slot, e_att, e_base, e_state, e_cnt_in, e_sample;

    function automatic int ref_next(int st, int lk, int kon, int eg, int slv, int et);
        int sle;
        sle = (slv == 15) ? 31 : slv;
        if (kon == 1 && lk == 0) return 0;
        if (kon == 0 && st != 3) return 3;
        if (st == 0 && eg == 0) return 1;
        if (st == 1 && (eg / 16) >= sle) return (et != 0) ? 2 : 3;
        if (st == 2 && et == 0) return 3;
        return st;
    endfunction

    function automatic int ref_base(int st, int c);
        int rate;
        if (st == 0)      rate = t_ar[c];
        else if (st == 1) rate = t_dr[c];
        else if (st == 2) rate = (t_et[c] != 0) ? 0 : t_rr[c];
        else              rate = t_rr[c];
        return rate * 2;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs for the model's current slot, advance model, compare
    task automatic cyc(input bit do_cen, input bit do_rst);
        int c, ns, cl, old_slot;
        c = m_cur;
        if (rnd_mode != 0) begin
            if ($urandom_range(0, 3) == 0) t_kon[c] = 1 - t_kon[c];
            t_ar[c] = $urandom_range(0, 15);
            t_dr[c] = $urandom_range(0, 15);
            t_sl[c] = $urandom_range(0, 15);
            t_rr[c] = $urandom_range(0, 15);
            t_et[c] = $urandom_range(0, 1);
            t_eg[c] = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 511);
        end
        cl = (cl_mode != 0) ? ((e_slot == 5) ? 1 : 0) : $urandom_range(0, 1);
        rst = do_rst; cen = do_cen;
        keyon = 1'(t_kon[c]); ar = 4'(t_ar[c]); dr = 4'(t_dr[c]);
        sl = 4'(t_sl[c]); rr = 4'(t_rr[c]); eg_type = 1'(t_et[c]);
        eg_in = 9'(t_eg[c]); cnt_lsb = 1'(cl);
        @(posedge clk);
        if (do_rst) begin
            for (int i = 0; i < SLOTS; i++) begin
                m_st[i] = 3; m_lk[i] = 0; m_mem[i] = 0;
            end
            m_cur = 0; m_egcnt = 0;
            e_slot = 0; e_att = 0; e_base = 0; e_state = 0; e_cnt_in = 0; e_sample = 0;
        end else if (do_cen) begin
            ns = ref_next(m_st[c], m_lk[c], t_kon[c], t_eg[c], t_sl[c], t_et[c]);
            m_st[c] = ns;
            m_lk[c] = t_kon[c];
            old_slot = e_slot;
            e_cnt_in = m_mem[c];
            m_mem[old_slot] = cl;
            e_slot = c; e_state = ns; e_att = (ns == 0) ? 1 : 0;
            e_base = ref_base(ns, c);
            e_sample = (c == 0) ? 1 : 0;
            if (c == SLOTS - 1) m_egcnt = (m_egcnt + 1) % (1 << CNTW);
            m_cur = (c + 1) % SLOTS;
        end else begin
            e_sample = 0;
        end
        #1;
        chk("slot_out", int'(slot_out), e_slot);
        chk("state_out", int'(state_out), e_state);
        chk("attack", int'(attack), e_att);
        chk("base_rate", int'(base_rate), e_base);
        chk("cnt_in", int'(cnt_in), e_cnt_in);
        chk("eg_cnt", int'(eg_cnt), m_egcnt);
        chk("sample", int'(sample), e_sample);
    endtask

    // Advance until the given slot has just been presented on the outputs
    task automatic run_to(input int tgt);
        for (int i = 0; i < 2 * SLOTS; i++) begin
            cyc(1'b1, 1'b0);
            if (e_slot == tgt) break;
        end
        chk("run_to", int'(slot_out), tgt);
    endtask

    initial begin
        for (int i = 0; i < SLOTS; i++) begin
            t_kon[i] = 1; t_ar[i] = 1; t_dr[i] = 1; t_sl[i] = 0;
            t_rr[i] = 1; t_et[i] = 1; t_eg[i] = 300;
        end
        e_slot = 0;
        cyc(1'b1, 1'b1);

        // Mid-ring reset with keyon held high
        for (int i = 0; i < 7; i++) cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b1);
        chk("rst_slot", int'(slot_out), 0);
        chk("rst_cnt", int'(eg_cnt), 0);
        chk("rst_state", int'(state_out), 0);
        chk("rst_base", int'(base_rate), 0);
        for (int i = 0; i < SLOTS; i++) t_kon[i] = 0;
        for (int i = 0; i < SLOTS; i++) begin
            cyc(1'b1, 1'b0);
            chk("rst_release", int'(state_out), 3);
        end

        // Key-on on slots 3 and 4
        t_kon[3] = 1; t_ar[3] = 10; t_dr[3] = 7; t_sl[3] = 15; t_et[3] = 1; t_rr[3] = 5; t_eg[3] = 100;
        t_kon[4] = 1; t_ar[4] = 10; t_dr[4] = 7; t_sl[4] = 15; t_et[4] = 0; t_rr[4] = 6; t_eg[4] = 100;
        run_to(3);
        chk("ko_state", int'(state_out), 0);
        chk("ko_attack", int'(attack), 1);
        chk("ko_base", int'(base_rate), 20);
        run_to(4);
        chk("ko4_state", int'(state_out), 0);

        // Attack reaches zero attenuation -> decay
        t_eg[3] = 0; t_eg[4] = 0;
        run_to(3);
        chk("dec_state", int'(state_out), 1);
        chk("dec_base", int'(base_rate), 14);
        chk("dec_attack", int'(attack), 0);
        run_to(4);
        chk("dec4_state", int'(state_out), 1);

        // Decay hits sl=15 threshold: sustained vs percussive
        t_eg[3] = 496; t_eg[4] = 496;
        run_to(3);
        chk("sus_state", int'(state_out), 2);
        chk("sus_base", int'(base_rate), 0);
        run_to(4);
        chk("perc_state", int'(state_out), 3);
        chk("perc_base", int'(base_rate), 12);

        // Key-off during attack with rr=0
        t_kon[6] = 1; t_ar[6] = 3; t_rr[6] = 0; t_eg[6] = 200;
        run_to(6);
        chk("ka_state", int'(state_out), 0);
        chk("ka_base", int'(base_rate), 6);
        t_kon[6] = 0;
        run_to(6);
        chk("koff_state", int'(state_out), 3);
        chk("koff_base", int'(base_rate), 0);
        chk("koff_attack", int'(attack), 0);

        // cnt memory: only slot 5 stores a 1
        cl_mode = 1;
        for (int i = 0; i < 2 * SLOTS; i++) cyc(1'b1, 1'b0);
        for (int i = 0; i < SLOTS; i++) begin
            cyc(1'b1, 1'b0);
            chk("cntmem", int'(cnt_in), (e_slot == 5) ? 1 : 0);
        end
        cl_mode = 0;

        // Random rings with periodic cen gaps, long enough to wrap eg_cnt
        rnd_mode = 1;
        for (int i = 0; i < 400; i++) cyc((i % 7) != 6, 1'b0);
        for (int i = 0; i < 200; i++) cyc($urandom_range(0, 3) != 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
